// File: rtl/inertial_integrator.sv
// Gyro offset removal, pitch-rate integration and complementary fusion with accelerometer pitch.
// Define INERT_CAL_EN to build the power-up gyro offset calibration; otherwise PTCH_RT_OFFSET is used.
module inertial_integrator #(
    parameter int          CAL_SHIFT      = 4,
    parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
    parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld_in,
    input  logic [15:0] ptch_rt_raw,
    input  logic [15:0] AZ,
    input  logic        clr,
    output logic [15:0] ptch,
    output logic [15:0] ptch_rt,
    output logic        vld,
    output logic        cal_done
);
    localparam logic [26:0] FUSION_POS = 27'd1024;
    localparam logic [26:0] FUSION_NEG = -27'sd1024;

    logic [26:0] ptch_int_q, ptch_int_d;
    logic [15:0] ptch_rt_q, ptch_rt_d;
    logic        vld_q, vld_d;
    logic        cal_done_q, cal_done_d;
    logic [15:0] offset;
    logic        run;

    logic [16:0] rt_diff;
    logic [15:0] ptch_rt_comp;
    logic [15:0] az_comp;
    logic signed [25:0] acc_prod;
    logic signed [15:0] ptch_acc;
    logic [26:0] fusion;

`ifdef INERT_CAL_EN
    localparam int SUM_W = 16 + CAL_SHIFT;

    typedef enum logic {CAL, RUN} state_t;

    state_t               state_q, state_d;
    logic [SUM_W-1:0]     sum_q, sum_d, sum_next;
    logic [CAL_SHIFT-1:0] cnt_q, cnt_d;
    logic [15:0]          offset_q, offset_d;

    // The last calibration sample is folded into the average on the same edge that enters RUN.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        offset_d   = offset_q;
        cal_done_d = cal_done_q;
        sum_next   = sum_q + {{CAL_SHIFT{ptch_rt_raw[15]}}, ptch_rt_raw};
        if (state_q == CAL && vld_in) begin
            sum_d = sum_next;
            cnt_d = cnt_q + CAL_SHIFT'(1);
            if (&cnt_q) begin
                offset_d   = 16'($signed(sum_next) >>> CAL_SHIFT);
                sum_d      = '0;
                cnt_d      = '0;
                state_d    = RUN;
                cal_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= CAL;
            sum_q    <= '0;
            cnt_q    <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            offset_q <= offset_d;
        end
    end

    assign run    = (state_q == RUN);
    assign offset = offset_q;
`else
    assign run        = 1'b1;
    assign offset     = PTCH_RT_OFFSET;
    assign cal_done_d = 1'b1;
`endif

    // Offset removal saturates rather than wraps so a railed gyro cannot flip sign.
    always_comb begin
        rt_diff = {ptch_rt_raw[15], ptch_rt_raw} - {offset[15], offset};
        if (rt_diff[16] != rt_diff[15]) begin
            ptch_rt_comp = rt_diff[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            ptch_rt_comp = rt_diff[15:0];
        end
        az_comp  = AZ - AZ_OFFSET;
        acc_prod = $signed({{10{az_comp[15]}}, az_comp}) * 26'sd327;
        ptch_acc = 16'(acc_prod >>> 13);
        fusion   = ($signed(ptch_acc) > $signed(ptch)) ? FUSION_POS : FUSION_NEG;
    end

    always_comb begin
        ptch_int_d = ptch_int_q;
        ptch_rt_d  = ptch_rt_q;
        vld_d      = 1'b0;
        if (run && vld_in) begin
            ptch_rt_d  = ptch_rt_comp;
            vld_d      = 1'b1;
            ptch_int_d = ptch_int_q - {{11{ptch_rt_comp[15]}}, ptch_rt_comp} + fusion;
        end
        if (clr) begin
            ptch_int_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_int_q <= '0;
            ptch_rt_q  <= '0;
            vld_q      <= 1'b0;
            cal_done_q <= 1'b0;
        end else begin
            ptch_int_q <= ptch_int_d;
            ptch_rt_q  <= ptch_rt_d;
            vld_q      <= vld_d;
            cal_done_q <= cal_done_d;
        end
    end

    assign ptch     = ptch_int_q[26:11];
    assign ptch_rt  = ptch_rt_q;
    assign vld      = vld_q;
    assign cal_done = cal_done_q;
endmodule
